// File: rtl/register_file_ext.sv
`default_nettype none
// ============================================================================
// register_file_ext : parametrised 2-read/1-write register file with masked
// flag update, multi-cycle bulk-clear sweep and optional A-port forwarding
// (macro REGFILE_BYPASS_EN). Revision 1.0
// ============================================================================
module register_file_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int GOUT_ADDR  = 29,
  parameter int DOUT_ADDR  = 30,
  parameter int FLAG_ADDR  = 31,
  parameter bit ZERO_REG0  = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_data_out,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data_in,
  input  logic                  b_wr_enable,
  output logic [DATA_WIDTH-1:0] b_data_out,
  input  logic [DATA_WIDTH-1:0] flag_wr_mask,
  input  logic [DATA_WIDTH-1:0] flag_data_in,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] reg_gout,
  output logic [DATA_WIDTH-1:0] reg_dout,
  output logic [DATA_WIDTH-1:0] reg_flag
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] C_GOUT = ADDR_WIDTH'(GOUT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] C_DOUT = ADDR_WIDTH'(DOUT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] C_FLAG = ADDR_WIDTH'(FLAG_ADDR);
  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(DEPTH-1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_e;

  state_e                  state_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

  logic                    w_open;
  logic                    w_wr;
  logic [DATA_WIDTH-1:0]   w_flag_base;
  logic [DATA_WIDTH-1:0]   w_flag_d;

  assign w_open = enable && !busy_q;
  assign w_wr   = w_open && b_wr_enable && !(ZERO_REG0 && (b_addr == '0));

  // Unmasked flag bits take the port B write data when B targets the flag register.
  assign w_flag_base = (w_wr && (b_addr == C_FLAG)) ? b_data_in : regs_q[C_FLAG];
  assign w_flag_d    = (w_flag_base & ~flag_wr_mask) | (flag_data_in & flag_wr_mask);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (w_wr) begin
            regs_q[b_addr] <= b_data_in;
          end
          regs_q[C_FLAG] <= w_flag_d;
          if (clear_req) begin
            state_q <= S_SWEEP;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
        S_SWEEP: begin
          regs_q[ptr_q] <= '0;
          if (ptr_q == C_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    a_data_out = regs_q[a_addr];
`ifdef REGFILE_BYPASS_EN
    if (w_open && (a_addr == C_FLAG)) begin
      a_data_out = w_flag_d;
    end else if (w_wr && (a_addr == b_addr)) begin
      a_data_out = b_data_in;
    end
`endif
    if (ZERO_REG0 && (a_addr == '0)) begin
      a_data_out = '0;
    end
  end

  always_comb begin
    b_data_out = regs_q[b_addr];
    if (ZERO_REG0 && (b_addr == '0)) begin
      b_data_out = '0;
    end
  end

  assign busy     = busy_q;
  assign reg_gout = regs_q[C_GOUT];
  assign reg_dout = regs_q[C_DOUT];
  assign reg_flag = regs_q[C_FLAG];

endmodule
`default_nettype wire

// File: doc/register_file_ext.md
Name: register_file_ext

Overview:
- Parametrised successor to the CPU's 32x8 register file.
- Width, depth and special-register addresses are configurable.
- Adds a masked flag-update port for ALU condition bits, a multi-cycle bulk-clear sweep with a busy indication, and optional write-to-read forwarding.
- Sits between the CPU control/ALU and the GOUT/DOUT/FLAG consumers.

Parameters:
- DATA_WIDTH, 8, bits per register.
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH registers.
- GOUT_ADDR, 29, address of general-output register.
- DOUT_ADDR, 30, address of display-output register.
- FLAG_ADDR, 31, address of flag register.
- ZERO_REG0, 0, when 1 register 0 reads as zero and ignores writes.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- enable  input  1  global advance; when low, no register state or FSM state changes
- a_addr  input  ADDR_WIDTH  port A read address
- a_data_out  output  DATA_WIDTH  port A read data, combinational
- b_addr  input  ADDR_WIDTH  port B read/write address
- b_data_in  input  DATA_WIDTH  port B write data
- b_wr_enable  input  1  port B write request
- b_data_out  output  DATA_WIDTH  port B read data, combinational
- flag_wr_mask  input  DATA_WIDTH  per-bit flag update enable
- flag_data_in  input  DATA_WIDTH  flag update data
- clear_req  input  1  start bulk-clear sweep
- busy  output  1  registered; high while sweep in progress
- reg_gout  output  DATA_WIDTH  stored contents of GOUT_ADDR
- reg_dout  output  DATA_WIDTH  stored contents of DOUT_ADDR
- reg_flag  output  DATA_WIDTH  stored contents of FLAG_ADDR

Behaviour:
- Reset (resetn low, asynchronous): all registers 0, FSM IDLE, sweep pointer 0, busy 0. Reset mid-sweep aborts the sweep; IDLE on release.
- Port B write: at posedge when enable && b_wr_enable && !busy, reg[b_addr] <= b_data_in. Dropped when busy=1. With ZERO_REG0=1, writes to address 0 are dropped.
- Flag update: at posedge when enable && !busy, reg[FLAG_ADDR][i] <= flag_data_in[i] for each bit i with flag_wr_mask[i]=1. Unmasked bits are unchanged.
- Simultaneous port B write to FLAG_ADDR and flag update: per bit, masked bits take flag_data_in and unmasked bits take b_data_in.
- Reads: a_data_out = reg[a_addr] and b_data_out = reg[b_addr], combinational, zero latency. With ZERO_REG0=1, address 0 reads 0.
- reg_gout, reg_dout and reg_flag always show stored values and are never forwarded.
- FSM has two states:
  - IDLE -> SWEEP: at posedge with enable && clear_req. busy goes 1 that edge; ptr=0. A port B write or flag update presented in the same cycle is still performed; the sweep clears it later.
  - SWEEP: each enabled posedge, reg[ptr] <= 0 and ptr <= ptr+1. With enable low, the sweep freezes and busy holds.
  - SWEEP -> IDLE: at the edge that clears ptr=DEPTH-1; busy drops that edge. The sweep takes exactly DEPTH enabled cycles.
  - clear_req during SWEEP is ignored; it does not restart the sweep.
- Reads during SWEEP return current stored contents, so the register file is partially cleared.
- Special addresses must be distinct and < DEPTH. ZERO_REG0=1 with a special address of 0 is illegal.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when enable && b_wr_enable && !busy && b_addr == a_addr (and not the zeroed reg 0), a_data_out returns the value being written this cycle. For FLAG_ADDR the returned value is the merged per-bit value including the flag update. A flag-only update to FLAG_ADDR also forwards to port A reads of FLAG_ADDR. b_data_out is never forwarded.
- Undefined: reads always return stored contents; new values are visible the cycle after the edge.

Test Plan:
- Reset, then write 8'hA5 to addr 29 and 8'h3C to addr 30 -> next cycle reg_gout=8'hA5, reg_dout=8'h3C, a_data_out at addr 29 = 8'hA5; with resetn pulsed low, all outputs read 0 immediately.
- reg[31]=8'hF0; one cycle with port B write 8'h0F to addr 31, flag_wr_mask=8'h03, flag_data_in=8'h02 -> reg_flag=8'h0E.
- Fill all 32 regs with nonzero data, assert clear_req one cycle -> busy=1 for exactly 32 enabled cycles. reg[k] reads 0 after edge k+1. Writes during busy leave targets 0. Final state all 0, busy=0.
- Mid-sweep: drop enable for 5 cycles -> ptr and busy frozen, then resume; total enabled sweep cycles still 32. Assert resetn low mid-sweep -> busy=0 immediately, all regs 0.
- ZERO_REG0=1: write 8'hFF to addr 0 -> a_data_out and b_data_out at addr 0 read 0.
- REGFILE_BYPASS_EN defined: a_addr=b_addr=5, write 8'h77 -> a_data_out=8'h77 in the same cycle. Undefined: a_data_out shows the old value until the next cycle.
